// File: rtl/mod_pipe_stage_pkg.sv
// mod_pipe_stage_pkg: shared pipeline stage state encoding and per-boundary payload structs
package mod_pipe_stage_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } pipe_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } if2id_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] rs1_val;
        logic [31:0] rs2_val;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic [3:0]  alu_op;
    } id2ex_t;

    typedef struct packed {
        logic [31:0] alu_res;
        logic [31:0] store_val;
        logic [4:0]  rd;
        logic        mem_we;
        logic        mem_re;
    } ex2mem_t;

    typedef struct packed {
        logic [31:0] wb_val;
        logic [4:0]  rd;
        logic        wb_en;
    } mem2wb_t;

endpackage

// File: rtl/mod_pipe_stage_cnt_sat.sv
// mod_pipe_cnt_sat: saturating up-counter for performance statistics
module mod_pipe_cnt_sat #(
    parameter int W = 16
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);
    logic [W-1:0] cnt_q, cnt_d;

    always_comb cnt_d = (inc_i && !(&cnt_q)) ? cnt_q + 1'b1 : cnt_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign cnt_o = cnt_q;
endmodule

// File: rtl/mod_pipe_stage.sv
// mod_pipe_stage: handshaked pipeline register with flush, optional skid buffer and stall counter
module mod_pipe_stage
    import mod_pipe_stage_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int SKID   = 0,
    parameter int CNT_W  = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              flush_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [DATA_W-1:0] in_data_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DATA_W-1:0] out_data_o,
    output logic [1:0]        occ_o,
    output logic [CNT_W-1:0]  stall_cnt_o
);
    logic in_xfer, out_xfer;

    assign in_xfer  = in_valid_i && in_ready_o;
    assign out_xfer = out_valid_o && out_ready_i;

    generate
        if (SKID == 0) begin : g_reg
            logic              valid_q, valid_d;
            logic [DATA_W-1:0] main_q, main_d;
            always_comb begin
                valid_d = flush_i ? 1'b0 : in_xfer ? 1'b1 : out_xfer ? 1'b0 : valid_q;
                main_d  = (in_xfer && !flush_i) ? in_data_i : main_q;
            end
            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    valid_q <= 1'b0;
                    main_q  <= '0;
                end else begin
                    valid_q <= valid_d;
                    main_q  <= main_d;
                end
            end
            assign in_ready_o  = !valid_q || out_ready_i;
            assign out_valid_o = valid_q;
            assign out_data_o  = main_q;
            assign occ_o       = {1'b0, valid_q};
        end else begin : g_skid
            pipe_state_e       state_q, state_d;
            logic [DATA_W-1:0] main_q, main_d, skid_q, skid_d;
            logic              rdy_q;
            always_comb begin
                state_d = state_q;
                main_d  = main_q;
                skid_d  = skid_q;
                if (flush_i) begin
                    state_d = EMPTY;
                end else begin
                    case (state_q)
                        EMPTY: if (in_xfer) begin
                            state_d = BUSY;
                            main_d  = in_data_i;
                        end
                        BUSY: if (in_xfer && out_xfer) begin
                            main_d = in_data_i;
                        end else if (in_xfer) begin
                            state_d = FULL;
                            skid_d  = in_data_i;
                        end else if (out_xfer) begin
                            state_d = EMPTY;
                        end
                        FULL: if (out_xfer) begin
                            state_d = BUSY;
                            main_d  = skid_q;
                        end
                        default: state_d = EMPTY;
                    endcase
                end
            end
            // Ready is registered from the next state so out_ready_i never reaches in_ready_o combinationally.
            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    state_q <= EMPTY;
                    main_q  <= '0;
                    skid_q  <= '0;
                    rdy_q   <= 1'b1;
                end else begin
                    state_q <= state_d;
                    main_q  <= main_d;
                    skid_q  <= skid_d;
                    rdy_q   <= (state_d != FULL);
                end
            end
            assign in_ready_o  = rdy_q;
            assign out_valid_o = (state_q != EMPTY);
            assign out_data_o  = main_q;
            assign occ_o       = state_q;
        end
    endgenerate

    mod_pipe_cnt_sat #(.W(CNT_W)) u_stall_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .inc_i (out_valid_o && !out_ready_i && !flush_i),
        .cnt_o (stall_cnt_o)
    );
endmodule

// File: tb/tb_mod_pipe_stage.sv
// tb_mod_pipe_stage: scoreboard bench for register (SKID=0) and skid (SKID=1, CNT_W=4) variants
module tb_mod_pipe_stage;
    logic        clk = 1'b0;
    logic        rst [2];
    logic        flush [2];
    logic        in_valid [2];
    logic        in_ready [2];
    logic [31:0] in_data [2];
    logic        out_valid [2];
    logic        out_ready [2];
    logic [31:0] out_data [2];
    logic [1:0]  occ [2];
    logic [15:0] sc0;
    logic [3:0]  sc1;
    logic [31:0] sb0 [$];
    logic [31:0] sb1 [$];
    int          tests = 0;
    int          fails = 0;
    int          cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    mod_pipe_stage #(.DATA_W(32), .SKID(0), .CNT_W(16)) u0 (
        .clk_i(clk), .rst_i(rst[0]), .flush_i(flush[0]),
        .in_valid_i(in_valid[0]), .in_ready_o(in_ready[0]), .in_data_i(in_data[0]),
        .out_valid_o(out_valid[0]), .out_ready_i(out_ready[0]), .out_data_o(out_data[0]),
        .occ_o(occ[0]), .stall_cnt_o(sc0)
    );

    mod_pipe_stage #(.DATA_W(32), .SKID(1), .CNT_W(4)) u1 (
        .clk_i(clk), .rst_i(rst[1]), .flush_i(flush[1]),
        .in_valid_i(in_valid[1]), .in_ready_o(in_ready[1]), .in_data_i(in_data[1]),
        .out_valid_o(out_valid[1]), .out_ready_i(out_ready[1]), .out_data_o(out_data[1]),
        .occ_o(occ[1]), .stall_cnt_o(sc1)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst[0] && !flush[0] && out_valid[0] && out_ready[0]) begin
            if (sb0.size() == 0) begin
                tests++; fails++;
                $display("FAIL mon0_unexpected: got %h expected none", out_data[0]);
            end else chk("mon0_data", out_data[0], sb0.pop_front());
        end
        if (!rst[1] && !flush[1] && out_valid[1] && out_ready[1]) begin
            if (sb1.size() == 0) begin
                tests++; fails++;
                $display("FAIL mon1_unexpected: got %h expected none", out_data[1]);
            end else chk("mon1_data", out_data[1], sb1.pop_front());
        end
    end

    task automatic push(input int k, input logic [31:0] d);
        bit ok = 1'b0;
        int n = 0;
        in_valid[k] = 1'b1;
        in_data[k]  = d;
        while (!ok && n < 20) begin
            @(negedge clk);
            ok = in_ready[k];
            if (ok) begin
                if (k == 0) sb0.push_back(d);
                else        sb1.push_back(d);
            end
            @(posedge clk);
            #1;
            n++;
        end
        if (!ok) begin
            tests++; fails++;
            $display("FAIL push_timeout: got no ready expected ready for %h", d);
        end
        in_valid[k] = 1'b0;
    endtask

    task automatic flush_hit(input int k);
        flush[k]    = 1'b1;
        in_valid[k] = 1'b1;
        in_data[k]  = 32'h3;
        @(posedge clk);
        #1;
        flush[k]    = 1'b0;
        in_valid[k] = 1'b0;
        if (k == 0) sb0.delete();
        else        sb1.delete();
    endtask

    task automatic stream(input int k);
        int c0 = cyc;
        for (int i = 0; i < 100; i++) push(k, 32'h1000 + i);
        chk(k == 0 ? "s0_rate" : "s1_rate", cyc - c0, 100);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk(k == 0 ? "s0_drain" : "s1_drain", k == 0 ? sb0.size() : sb1.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        for (int k = 0; k < 2; k++) begin
            rst[k] = 1'b1; flush[k] = 1'b0; in_valid[k] = 1'b0;
            in_data[k] = '0; out_ready[k] = 1'b1;
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            chk("rst_valid", out_valid[k], 0);
            chk("rst_data", out_data[k], 0);
            chk("rst_occ", occ[k], 0);
            chk("rst_ready", in_ready[k], 1);
        end
        chk("rst_sc0", sc0, 0);
        chk("rst_sc1", sc1, 0);
        @(posedge clk); #1;
        rst[0] = 1'b0; rst[1] = 1'b0;

        push(0, 32'hDEADBEEF);
        @(negedge clk);
        chk("t1_valid", out_valid[0], 1);
        chk("t1_data", out_data[0], 32'hDEADBEEF);
        chk("t1_occ", occ[0], 1);
        @(posedge clk); #1;
        stream(0);
        chk("s0_stall", sc0, 0);

        @(posedge clk); #1;
        out_ready[0] = 1'b0;
        push(0, 32'h55);
        repeat (20) @(posedge clk);
        @(negedge clk);
        chk("st0_cnt", sc0, 20);
        chk("st0_hold", out_data[0], 32'h55);
        chk("st0_ready", in_ready[0], 0);
        @(posedge clk); #1;
        out_ready[0] = 1'b1;
        flush_hit(0);
        @(negedge clk);
        chk("f0_valid", out_valid[0], 0);
        chk("f0_occ", occ[0], 0);
        chk("f0_ready", in_ready[0], 1);
        repeat (2) @(negedge clk);
        chk("f0_quiet", out_valid[0], 0);

        @(posedge clk); #1;
        stream(1);
        chk("s1_stall", sc1, 0);

        @(posedge clk); #1;
        out_ready[1] = 1'b0;
        push(1, 32'h1);
        push(1, 32'h2);
        @(negedge clk);
        chk("bp_occ", occ[1], 2);
        chk("bp_ready", in_ready[1], 0);
        chk("bp_data", out_data[1], 32'h1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("bp_hold", out_data[1], 32'h1);
        chk("bp_ready2", in_ready[1], 0);
        @(posedge clk); #1;
        out_ready[1] = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("bp_second_valid", out_valid[1], 1);
        chk("bp_second_data", out_data[1], 32'h2);
        @(negedge clk);
        chk("bp_empty", out_valid[1], 0);
        chk("bp_ready3", in_ready[1], 1);

        @(posedge clk); #1;
        out_ready[1] = 1'b0;
        push(1, 32'hA1);
        push(1, 32'hA2);
        flush_hit(1);
        @(negedge clk);
        chk("fc_valid", out_valid[1], 0);
        chk("fc_occ", occ[1], 0);
        chk("fc_ready", in_ready[1], 1);
        @(posedge clk); #1;
        out_ready[1] = 1'b1;
        repeat (3) @(negedge clk);
        chk("fc_quiet", out_valid[1], 0);

        @(posedge clk); #1;
        rst[1] = 1'b1;
        sb1.delete();
        @(posedge clk); #1;
        rst[1] = 1'b0;
        out_ready[1] = 1'b0;
        push(1, 32'hA5);
        repeat (20) @(posedge clk);
        @(negedge clk);
        chk("sat_cnt", sc1, 15);
        chk("sat_data", out_data[1], 32'hA5);
        repeat (3) @(negedge clk);
        chk("sat_hold", sc1, 15);

        @(posedge clk); #1;
        rst[1] = 1'b1;
        sb1.delete();
        @(posedge clk);
        @(negedge clk);
        chk("mr_valid", out_valid[1], 0);
        chk("mr_data", out_data[1], 0);
        chk("mr_occ", occ[1], 0);
        chk("mr_ready", in_ready[1], 1);
        chk("mr_cnt", sc1, 0);
        @(posedge clk); #1;
        rst[1] = 1'b0;
        repeat (2) @(negedge clk);
        chk("end_sb0", sb0.size(), 0);
        chk("end_sb1", sb1.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
